opcode_sequencer: RTL and testbench

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

---
 rtl/opcode_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_opcode_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_sequencer.sv
// ---------------------------------------------------------------------------
// opcode_sequencer
//
// This block holds a small program of 16-bit words and issues them one per
// clock to a core array. Control words are executed internally: HALT, SETCNT,
// DJNZ and NOP. They are never issued to the array. Data words are issued
// through the registered opcode/execute pair.
//
// Ports
//   clk         : single clock, all logic on the rising edge
//   rst_n       : asynchronous active-low reset (program memory is kept)
//   prog_we     : program-memory write enable (accepted in any state)
//   prog_addr   : program-memory write address
//   prog_wdata  : program-memory write data
//   start       : begin execution at address 0 (only honoured in IDLE)
//   abort       : leave RUN immediately, with no done pulse
//   stall       : freeze issue (pc, loop counter and opcode are held)
//   opcode      : registered opcode for the core array
//   execute     : registered opcode-valid strobe
//   busy        : high while the sequencer is in RUN
//   done        : one-cycle pulse after a HALT word is executed
// ---------------------------------------------------------------------------
module opcode_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_wdata,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  output logic [15:0]           opcode,
  output logic                  execute,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SUB_HALT   = 2'b00;
  localparam logic [1:0] SUB_SETCNT = 2'b01;
  localparam logic [1:0] SUB_DJNZ   = 2'b10;
  localparam logic [1:0] SUB_NOP    = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]            loop_cnt_q, loop_cnt_d;
  logic [15:0]           opcode_q, opcode_d;
  logic                  execute_q, execute_d;
  logic                  done_q, done_d;

  logic [15:0]           mem [PROG_DEPTH];
  logic [15:0]           fetch_word;
  logic                  is_ctrl;
  logic [1:0]            sub_op;
  logic [31:0]           target_ext;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pc_inc;

  // Sequential successor of a program address, wrapping at the last word
  // (also correct when PROG_DEPTH is not a power of two).
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    if (pc == LAST_ADDR) begin
      return ADDR_ZERO;
    end else begin
      return pc + ADDR_ONE;
    end
  endfunction

  // Program memory write port; deliberately not reset so the program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // Asynchronous fetch at pc; a write landing on the same edge only shows up
  // on the next fetch because pc_q/mem are both updated at that edge.
  always_comb begin
    fetch_word = mem[pc_q];
    is_ctrl    = (fetch_word[15:14] == 2'b11) && (fetch_word[8] == 1'b1);
    sub_op     = fetch_word[1:0];
    // Jump target is a 5-bit field; zero-extend then truncate to the pc width.
    target_ext = {27'd0, fetch_word[13:9]};
    target     = target_ext[ADDR_WIDTH-1:0];
    pc_inc     = next_pc(pc_q);
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    opcode_d   = opcode_q;
    execute_d  = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_RUN;
          pc_d       = ADDR_ZERO;
          loop_cnt_d = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Priority: abort beats stall, and stall beats whatever word is fetched.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (!is_ctrl) begin
          opcode_d  = fetch_word;
          execute_d = 1'b1;
          pc_d      = pc_inc;
        end else begin
          case (sub_op)
            SUB_HALT: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
            SUB_SETCNT: begin
              loop_cnt_d = fetch_word[13:9];
              pc_d       = pc_inc;
            end
            SUB_DJNZ: begin
              if (loop_cnt_q != 5'd0) begin
                loop_cnt_d = loop_cnt_q - 5'd1;
                pc_d       = target;
              end else begin
                pc_d = pc_inc;
              end
            end
            SUB_NOP: begin
              pc_d = pc_inc;
            end
            default: begin
              pc_d = pc_inc;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pc, loop counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= ADDR_ZERO;
      loop_cnt_q <= 5'd0;
      opcode_q   <= 16'h0000;
      execute_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      opcode_q   <= opcode_d;
      execute_q  <= execute_d;
      done_q     <= done_d;
    end
  end

  assign opcode  = opcode_q;
  assign execute = execute_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_opcode_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for opcode_sequencer. An instruction-level reference model
// interprets the same program array that is written into the DUT. It produces
// the expected stream of issued words. Each scenario task runs the DUT and
// checks that stream cycle by cycle.
// ---------------------------------------------------------------------------
module tb_opcode_sequencer;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_wdata = 16'h0000;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic [15:0]   opcode;
  logic          execute;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] prog_m [DEPTH];
  logic [15:0] exp_q [$];
  bit          exp_halt;
  logic [15:0] last_issued;

  opcode_sequencer #(.PROG_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .abort      (abort),
    .stall      (stall),
    .opcode     (opcode),
    .execute    (execute),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_word(input logic [1:0] sub, input logic [4:0] t);
    return {2'b11, t, 1'b1, 6'b000000, sub};
  endfunction

  function automatic logic [15:0] rand_data();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:14] == 2'b11) w[8] = 1'b0;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_wdata = prog_m[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  // Instruction-level interpretation of the program: list of issued words.
  task automatic model_run(input int max_words);
    int pc;
    int cnt;
    logic [15:0] w;
    exp_q.delete();
    exp_halt = 1'b0;
    pc = 0;
    cnt = 0;
    for (int step = 0; step < 5000 && exp_q.size() < max_words; step++) begin
      w = prog_m[pc];
      if (w[15:14] == 2'b11 && w[8] == 1'b1) begin
        case (w[1:0])
          2'b00: begin exp_halt = 1'b1; return; end
          2'b01: begin cnt = int'(w[13:9]); pc = (pc + 1) % DEPTH; end
          2'b10: begin
            if (cnt != 0) begin cnt = cnt - 1; pc = int'(w[13:9]) % DEPTH; end
            else pc = (pc + 1) % DEPTH;
          end
          default: pc = (pc + 1) % DEPTH;
        endcase
      end else begin
        exp_q.push_back(w);
        pc = (pc + 1) % DEPTH;
      end
    end
  endtask

  // Start the program and compare every issued word against the model.
  task automatic run_check(input string name, input int max_words, input int stall_pct,
                           input bit rand_start, input int stall_at, output int issued);
    int idx;
    int cyc;
    bit st;
    bit got_done;
    idx = 0; cyc = 0; got_done = 1'b0;
    start = 1'b1; stall = 1'b0;
    tick();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || execute !== 1'b0) begin
      n_fail++; $display("FAIL %s_start: busy=%b execute=%b, required busy=1 execute=0", name, busy, execute);
    end
    while (cyc < 4000 && !got_done && idx < max_words) begin
      st = ($urandom_range(99) < stall_pct) ||
           (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      stall = st;
      start = rand_start ? 1'($urandom_range(1)) : 1'b0;
      tick();
      cyc++;
      if (done === 1'b1 && execute === 1'b1) begin
        n_tests++; n_fail++; $display("FAIL %s_done_exec: both high at cycle %0d", name, cyc);
      end
      if (st) begin
        n_tests++;
        if (execute !== 1'b0) begin
          n_fail++; $display("FAIL %s_stall: execute=%b during stall, required 0", name, execute);
        end
      end
      if (execute === 1'b1) begin
        n_tests++;
        if (idx >= exp_q.size()) begin
          n_fail++; $display("FAIL %s_extra: word %0d = %h issued, only %0d expected", name, idx, opcode, exp_q.size());
        end else if (opcode !== exp_q[idx]) begin
          n_fail++; $display("FAIL %s_word%0d: opcode=%h, required %h", name, idx, opcode, exp_q[idx]);
        end
        last_issued = opcode;
        idx++;
      end
      if (done === 1'b1) got_done = 1'b1;
    end
    stall = 1'b0; start = 1'b0;
    issued = idx;
    n_tests++;
    if (exp_halt) begin
      if (!got_done || idx != exp_q.size() || busy !== 1'b0) begin
        n_fail++; $display("FAIL %s_halt: done=%b issued=%0d busy=%b, required done=1 issued=%0d busy=0",
                           name, got_done, idx, busy, exp_q.size());
      end
      tick();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || execute !== 1'b0 || (idx > 0 && opcode !== last_issued)) begin
        n_fail++; $display("FAIL %s_after_halt: done=%b busy=%b execute=%b opcode=%h, required 0 0 0 %h",
                           name, done, busy, execute, opcode, last_issued);
      end
    end else begin
      if (got_done || idx != max_words || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s_running: done=%b issued=%0d busy=%b, required done=0 issued=%0d busy=1",
                           name, got_done, idx, busy, max_words);
      end
    end
  endtask

  task automatic stop_run(input string name);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || execute !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_abort: busy=%b execute=%b done=%b, required 0 0 0", name, busy, execute, done);
    end
  endtask

  // Start and wait for the second issued word; the bound guards a stuck DUT.
  task automatic run_to_second(input string name);
    int seen;
    seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      tick();
      if (execute === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 2 || opcode !== prog_m[1]) begin
      n_fail++; $display("FAIL %s_second: seen=%0d opcode=%h, required 2 words ending %h", name, seen, opcode, prog_m[1]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (opcode !== 16'h0000 || execute !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset: opcode=%h execute=%b busy=%b done=%b, required all 0", opcode, execute, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || execute !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b execute=%b, required 0", busy, execute);
    end
  endtask

  task automatic test_linear();
    int n;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 16'hC100;
    prog_m[0] = 16'h1234; prog_m[1] = 16'h2345; prog_m[2] = 16'hC100;
    load_prog();
    model_run(64);
    run_check("linear", 64, 0, 1'b0, -1, n);
    n_tests++;
    if (n != 2 || opcode !== 16'h2345) begin
      n_fail++; $display("FAIL linear_count: issued=%0d opcode=%h, required 2 and 2345", n, opcode);
    end
  endtask

  task automatic test_loop();
    int n;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 16'hC100;
    prog_m[0] = ctrl_word(2'b01, 5'd3);
    prog_m[1] = 16'h0011;
    prog_m[2] = ctrl_word(2'b10, 5'd1);
    prog_m[3] = ctrl_word(2'b00, 5'd0);
    load_prog();
    model_run(64);
    run_check("loop", 64, 0, 1'b0, -1, n);
    n_tests++;
    if (n != 4) begin
      n_fail++; $display("FAIL loop_count: 0011 issued %0d times, required 4", n);
    end
  endtask

  task automatic test_stall();
    int n;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 16'hC100;
    for (int i = 0; i < 8; i++) prog_m[i] = rand_data();
    prog_m[3] = ctrl_word(2'b11, 5'd7);
    load_prog();
    model_run(64);
    run_check("stall", 64, 0, 1'b0, 2, n);
    n_tests++;
    if (n != 7) begin
      n_fail++; $display("FAIL stall_count: issued=%0d, required 7", n);
    end
  endtask

  task automatic test_random();
    int n;
    int hp;
    for (int it = 0; it < 6; it++) begin
      hp = $urandom_range(31, 6);
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(9))
          0: prog_m[i] = ctrl_word(2'b11, 5'($urandom));
          1: prog_m[i] = {2'b11, 5'($urandom), 1'b0, 8'($urandom)};
          default: prog_m[i] = rand_data();
        endcase
      end
      prog_m[0]      = ctrl_word(2'b01, 5'($urandom_range(4)));
      prog_m[hp - 1] = ctrl_word(2'b10, 5'd1);
      prog_m[hp]     = ctrl_word(2'b00, 5'($urandom));
      load_prog();
      model_run(1000);
      run_check("random", 1000, 30, 1'b1, -1, n);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 16'hC100;
    for (int i = 0; i < 8; i++) prog_m[i] = rand_data();
    load_prog();
    run_to_second("abort");
    stop_run("abort_2nd");
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
    end
    // abort beats stall
    start = 1'b1; tick(); start = 1'b0;
    stall = 1'b1;
    stop_run("abort_stall");
    stall = 1'b0;
    // abort beats a HALT fetched on the same edge
    prog_m[0] = 16'hC100;
    prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = 16'hC100; tick(); prog_we = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    stop_run("abort_halt");
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 16'hC100;
    for (int i = 0; i < 6; i++) prog_m[i] = rand_data();
    load_prog();
    run_to_second("rst");
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (opcode !== 16'h0000 || execute !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: opcode=%h execute=%b busy=%b done=%b, required all 0", opcode, execute, busy, done);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (busy !== 1'b0 || execute !== 1'b0) begin
        n_fail++; $display("FAIL rst_idle: busy=%b execute=%b, required 0", busy, execute);
      end
    end
    // Program memory survives reset, so the same program runs again unchanged.
    model_run(64);
    run_check("rst_retain", 64, 20, 1'b0, -1, n);
  endtask

  task automatic test_wrap();
    int n;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = rand_data();
    load_prog();
    model_run(40);
    run_check("wrap", 40, 10, 1'b1, -1, n);
    n_tests++;
    if (last_issued !== prog_m[7]) begin
      n_fail++; $display("FAIL wrap_last: opcode=%h, required %h", last_issued, prog_m[7]);
    end
    stop_run("wrap");
  endtask

  task automatic test_write_during_fetch();
    logic [15:0] old_w;
    logic [15:0] new_w;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = 16'hC100;
    prog_m[0] = rand_data();
    prog_m[1] = rand_data();
    load_prog();
    old_w = prog_m[0];
    new_w = ~old_w;
    if (new_w[15:14] == 2'b11) new_w[8] = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = new_w;
    tick();
    prog_we = 1'b0;
    n_tests++;
    if (execute !== 1'b1 || opcode !== old_w) begin
      n_fail++; $display("FAIL same_cycle_write: execute=%b opcode=%h, required 1 %h", execute, opcode, old_w);
    end
    stop_run("same_cycle_write");
  endtask

  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (busy !== 1'b0 || execute !== 1'b0) begin
        n_fail++; $display("FAIL start_abort: busy=%b execute=%b, required 0", busy, execute);
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_linear();
    test_loop();
    test_stall();
    test_random();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_write_during_fetch();
    test_start_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
